pc_fetch_ctrl: RTL

- Program-counter register and fetch sequencer; sits directly upstream of PCPlus4.
- Drives PC into PCPlus4 and consumes its PCplus4 result as the sequential next address.
- Issues instruction-memory requests with a req/ack handshake, handles stalls and branch/jump redirects, and kills wrong-path fetches.
- Outputs a valid-qualified fetched PC to the decode side.

---
 rtl/pc_fetch_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Program-counter register and fetch sequencer. Drives PC into an external
//   PCPlus4 adder and takes its PCplus4 result as the sequential next address.
//   Issues instruction-memory requests with a req/ack handshake, handles
//   stalls and branch/jump redirects, and kills a wrong-path fetch that was
//   already in flight when a redirect arrived.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   stall             downstream busy; no new request is started
//   redirect          branch taken / jump this cycle
//   redirect_target   new PC for a redirect
//   PCplus4           PC + 4 from the external adder
//   imem_ack          memory completed the current request
//   PC                current fetch address (also feeds PCPlus4)
//   imem_req          request outstanding at PC
//   fetch_valid       one-cycle pulse, fetch_pc is a correct-path fetch
//   fetch_pc          address of the completed fetch
//   misalign_err      sticky: a misaligned redirect target was seen
//   redirect_count    accepted redirects (counter only built when
//                     PC_FETCH_REDIRECT_CNT_EN is defined, else constant 0)

module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  input  logic [31:0]      PCplus4,
  input  logic             imem_ack,
  output logic [31:0]      PC,
  output logic             imem_req,
  output logic             fetch_valid,
  output logic [31:0]      fetch_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_fv, w_fv_nxt;
  logic [31:0] r_fpc, w_fpc_nxt;
  logic        r_err, w_err_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic        w_misalign;

  assign w_misalign = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_fv    <= 1'b0;
      r_fpc   <= 32'h0;
      r_err   <= 1'b0;
      r_kill  <= 1'b0;
      r_pend  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_fv    <= w_fv_nxt;
      r_fpc   <= w_fpc_nxt;
      r_err   <= w_err_nxt;
      r_kill  <= w_kill_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_fv_nxt    = 1'b0;
    w_fpc_nxt   = r_fpc;
    w_err_nxt   = r_err;
    w_kill_nxt  = r_kill;
    w_pend_nxt  = r_pend;
    case (r_state)
      // Redirects during BOOT are dropped; nothing has been fetched yet.
      S_BOOT: w_state_nxt = stall ? S_HOLD : S_REQ;
      S_REQ: begin
        if (redirect && w_misalign) begin
          // Stop fetching; anything in flight is thrown away.
          w_err_nxt   = 1'b1;
          w_kill_nxt  = 1'b0;
          w_state_nxt = S_HALT;
        end else if (imem_ack) begin
          if (redirect) begin
            // A same-cycle redirect supersedes any pending one.
            w_pc_nxt   = redirect_target;
            w_kill_nxt = 1'b0;
          end else if (r_kill) begin
            // Wrong-path fetch completes: drop it and jump to the saved target.
            w_pc_nxt   = r_pend;
            w_kill_nxt = 1'b0;
          end else begin
            w_fv_nxt  = 1'b1;
            w_fpc_nxt = r_pc;
            w_pc_nxt  = PCplus4;
          end
          w_state_nxt = stall ? S_HOLD : S_REQ;
        end else if (redirect) begin
          // Request cannot be withdrawn; remember the target (last one wins).
          w_kill_nxt = 1'b1;
          w_pend_nxt = redirect_target;
        end
      end
      S_HOLD: begin
        if (redirect && w_misalign) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          if (redirect) w_pc_nxt = redirect_target;
          w_state_nxt = stall ? S_HOLD : S_REQ;
        end
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  assign PC           = r_pc;
  assign imem_req     = (r_state == S_REQ);
  assign fetch_valid  = r_fv;
  assign fetch_pc     = r_fpc;
  assign misalign_err = r_err;

`ifdef PC_FETCH_REDIRECT_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_redir_acc;

  // Every aligned redirect seen in REQ or HOLD, whether it loads PC directly
  // or goes through the kill path.
  assign w_redir_acc = redirect && !w_misalign &&
                       ((r_state == S_REQ) || (r_state == S_HOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_cnt <= '0;
    else if (w_redir_acc) r_cnt <= r_cnt + 1'b1;
  end

  assign redirect_count = r_cnt;
`else
  assign redirect_count = '0;
`endif

endmodule
